// File: rtl/neighbor_fifo_dispatch_if.sv
// rtl/neighbor_fifo_dispatch_if.sv - upstream FIFO read port and downstream valid/ready entry stream
interface neighbor_fifo_dispatch_if #(
  parameter int DATA_W = 64
);
  logic              fifo_rempty;
  logic              fifo_rinc;
  logic [DATA_W-1:0] fifo_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    input  fifo_rempty, fifo_rdata, out_ready,
    output fifo_rinc, out_valid, out_data
  );

  modport slave (
    output fifo_rempty, fifo_rdata, out_ready,
    input  fifo_rinc, out_valid, out_data
  );
endinterface

// File: rtl/neighbor_fifo_dispatch.sv
// rtl/neighbor_fifo_dispatch.sv - pulls neighbor-info entries from a FIFO into a 2-entry buffer and dispatches them
module neighbor_fifo_dispatch #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_drain_req,
  neighbor_fifo_dispatch_if.master bus,
  output logic                     o_drain_done,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_disp_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_disp_cnt;

  logic       w_active;
  logic       w_valid;
  logic       w_pop;
  logic       w_rinc;
  logic       w_drained;
  logic [1:0] w_level;
  logic [1:0] w_wr_idx;

  assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_valid   = !i_rst && (r_occ != 2'd0);
  assign w_pop     = w_valid && bus.out_ready;
  // Occupancy once this cycle's landing entry and pop settle; a read is only
  // issued if its data will still find a free slot next cycle.
  assign w_level   = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_wr_idx  = r_occ - {1'b0, w_pop};
  assign w_rinc    = !i_rst && w_active && !bus.fifo_rempty && (w_level < 2'd2);
  assign w_drained = (r_state == S_DRAIN) && bus.fifo_rempty && !r_inflight && (r_occ == 2'd0);

  assign bus.fifo_rinc = w_rinc;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? r_buf0 : '0;
  assign o_drain_done  = !i_rst && w_drained;
  assign o_busy        = !i_rst && ((r_state != S_IDLE) || (r_occ != 2'd0) || r_inflight);
  assign o_disp_cnt    = i_rst ? '0 : r_disp_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_disp_cnt <= '0;
    end else begin
      r_inflight <= w_rinc;
      r_occ      <= w_level;
      if (w_pop) begin
        r_buf0     <= r_buf1;
        r_disp_cnt <= r_disp_cnt + CNT_ONE;
      end
      // The landing entry goes behind whatever survives this cycle's pop.
      if (r_inflight) begin
        if (w_wr_idx == 2'd0) r_buf0 <= bus.fifo_rdata;
        else                  r_buf1 <= bus.fifo_rdata;
      end
      case (r_state)
        S_IDLE: begin
          if (i_drain_req)   r_state <= S_DRAIN;
          else if (i_enable) r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_drain_req)    r_state <= S_DRAIN;
          else if (!i_enable) r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (w_drained) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/neighbor_fifo_dispatch.md
NEIGHBOR_FIFO_DISPATCH -- requirements
Module: neighbor_fifo_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: width of one neighbor-info entry (packed Neighbor_info2Neighbor_FIFO).
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the dispatched-entry counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 enable  input  1  level; when 1, entries are pulled from the upstream neighbor FIFO.
REQ-006 drain_req  input  1  single-cycle pulse; requests a drain of the FIFO and internal buffer.
REQ-007 fifo_rempty  input  1  upstream FIFO empty flag.
REQ-008 fifo_rinc  output  1  upstream FIFO read-increment.
REQ-009 fifo_rdata  input  DATA_W  upstream FIFO read data, valid exactly one cycle after fifo_rinc; 0 otherwise.
REQ-010 out_valid  output  1  downstream entry valid.
REQ-011 out_data  output  DATA_W  downstream entry.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 drain_done  output  1  single-cycle pulse when a drain completes.
REQ-014 busy  output  1  1 when state is not IDLE or any entry is held or in flight.
REQ-015 disp_cnt  output  CNT_W  count of entries accepted downstream since reset.

Function
REQ-016 The block SHALL contain a 2-entry in-order buffer (occ in 0..2) and a 1-bit in-flight flag, inflight = fifo_rinc registered.
REQ-017 The block SHALL write fifo_rdata into the buffer tail in every cycle where inflight=1; no other write source exists.
REQ-018 out_valid SHALL equal (occ!=0); out_data SHALL be the buffer head; pop = out_valid & out_ready.
REQ-019 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 fifo_rinc SHALL be 1 only when state is RUN or DRAIN, fifo_rempty=0, and occ + inflight - pop < 2.
REQ-021 Simultaneous buffer write and pop SHALL leave occ unchanged and preserve order; no entry is ever dropped or duplicated.
REQ-022 With out_ready held at 1 and the FIFO non-empty, the block SHALL sustain one entry per cycle; first out_valid appears 2 cycles after the first fifo_rinc.
REQ-023 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-024 IDLE -> RUN when enable=1; IDLE -> DRAIN when drain_req=1 (drain_req has priority).
REQ-025 RUN -> IDLE when enable=0 (entries already held or in flight still complete and are presented); RUN -> DRAIN when drain_req=1.
REQ-026 DRAIN -> IDLE when fifo_rempty=1, inflight=0 and occ=0 in the same cycle; drain_done SHALL pulse 1 in that cycle.
REQ-027 drain_req in DRAIN SHALL be ignored; enable SHALL be ignored in DRAIN.
REQ-028 disp_cnt SHALL increment by 1 on each pop and wrap modulo 2^CNT_W.
REQ-029 fifo_rinc SHALL never assert when fifo_rempty=1.

Reset
REQ-030 While rst=1: state=IDLE, occ=0, inflight=0, disp_cnt=0, fifo_rinc=0, out_valid=0, out_data=0, drain_done=0, busy=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered and in-flight entries; fifo_rdata arriving the cycle after reset SHALL be ignored.
REQ-032 First fifo_rinc SHALL occur no earlier than the second cycle after rst deasserts.

Verification
REQ-033 FIFO preloaded with 5 entries 0x1..0x5, enable=1, out_ready=1 -> out_data 0x1..0x5 on 5 consecutive cycles, disp_cnt=5, fifo_rinc 5 cycles total.
REQ-034 4 entries, out_ready=0 for 10 cycles then 1 -> exactly 2 fifo_rinc while stalled, out_data=0x1 stable, then 0x1..0x4 in order, none lost.
REQ-035 enable=0, 3 entries in FIFO, drain_req pulse -> 3 entries out, drain_done pulses once when FIFO empty and occ=0, state back to IDLE, busy=0.
REQ-036 out_ready toggling 1/0 every cycle with 8 entries -> 8 entries in order, occ never exceeds 2, no fifo_rinc while fifo_rempty=1.
REQ-037 rst asserted 1 cycle after fifo_rinc with occ=2 -> next cycle out_valid=0, disp_cnt=0, late fifo_rdata not presented.
REQ-038 CNT_W=4, 17 entries dispatched -> disp_cnt=1 after wrap.
